interval_tick_servicer: RTL and testbench
=========================================

// Module: interval_tick_servicer
// PURPOSE
//  Hardware companion placed directly downstream of the interval timer. On timer irq it clears
//  the timer's TO flag via the timer's Avalon slave (status, addr 0), counts serviced ticks in
//  a 32-bit counter and raises a divided CPU interrupt every DIVIDE+1 ticks. Software reads and
//  clears tick count and event through its own Avalon-MM slave; no per-tick CPU ISR is needed.
// PARAMETERS
//  TMR_STATUS_ADDR  3'd0  timer register address written to clear TO
//  DIV_WIDTH        16    width of divide register and divide counter (<=16)
// PORTS
//  clk            in   1   single clock; all logic on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  address        in   3   CPU slave word address
//  chipselect     in   1   CPU slave select
//  read_n         in   1   CPU slave read strobe, active low
//  write_n        in   1   CPU slave write strobe, active low
//  writedata      in   16  CPU slave write data
//  readdata       out  16  CPU slave read data, registered, read latency 1
//  irq            out  1   divided-event interrupt to CPU
//  tmr_irq        in   1   level irq from interval timer
//  tmr_address    out  3   master address to timer slave
//  tmr_chipselect out  1   master select to timer slave
//  tmr_write_n    out  1   master write strobe, active low
//  tmr_writedata  out  16  master write data (always 0)
// BEHAVIOUR
//  Reset: readdata=0, irq=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=TMR_STATUS_ADDR,
//   tmr_writedata=0; ctrl=0, tick_cnt=0, tick_h_snap=0, divide=0, div_cnt=0, pending=0, FSM IDLE.
//  CPU map: 0 CTRL [0]=svc_en [1]=irq_en (RW); 1 TICK_L (R: also snapshots tick_cnt[31:16]);
//   2 TICK_H (R: snapshot); 3 DIVIDE (RW); 4 STATUS [0]=pending [1]=busy (R, any write clears
//   pending); unused addresses read 0. Write to 1 or 2 clears tick_cnt. readdata <= mux each clk.
//  FSM (registered outputs): IDLE -> CLR when svc_en & tmr_irq.
//   CLR: chipselect=1, write_n=0 for exactly one cycle (timer has no waitrequest) -> SETTLE.
//   SETTLE: one cycle, master idle, lets timer irq deassert (registered in timer) -> IDLE.
//   The tick is counted on the CLR cycle. busy = (state != IDLE). Max 1 tick per 3 clocks.
//  Tick accounting on CLR: tick_cnt+1 mod 2^32 (wraps 0xFFFFFFFF->0);
//   if div_cnt==divide: div_cnt=0, pending=1; else div_cnt+1.
//  DIVIDE=0 -> pending set on every tick. Write to DIVIDE also clears div_cnt.
//  irq = pending & irq_en (combinational from registers).
//  Simultaneous: pending set and CPU clear same cycle -> set wins. tick_cnt clear and increment
//   same cycle -> clear wins (result 0). DIVIDE write and tick same cycle -> div_cnt=0, no event.
//  svc_en cleared mid-sequence: CLR/SETTLE still complete; no new sequence starts.
//  tmr_irq held high after SETTLE (new timeout) -> immediately re-enters CLR, counts again.
//  reset_n asserted mid-sequence: master outputs return to idle values asynchronously.
// STRUCTURE
//  Package: register address constants (CTRL..STATUS), CTRL bit indices, FSM state enum
//   {IDLE, CLR, SETTLE}. Single module; no sub-modules (register file, FSM, counters inline).
// TESTING
//  1 Reset -> irq=0, tmr_chipselect=0, tmr_write_n=1, all CPU reads return 0.
//  2 CTRL=1, pulse tmr_irq high until cleared -> exactly one 1-cycle write to addr 0 data 0;
//    TICK_L reads 1, TICK_H reads 0.
//  3 DIVIDE=2, CTRL=3, 6 timer ticks -> irq rises after ticks 3 and 6; STATUS write drops irq.
//  4 Force tick_cnt=0xFFFFFFFF via 2^32-1 ticks (backdoor), one tick -> TICK_L=0, TICK_H=0.
//  5 STATUS write in same cycle pending sets (DIVIDE=0) -> pending stays 1, irq stays high.
//  6 Clear svc_en during CLR -> write completes, SETTLE entered, no further write with tmr_irq=1.

Source files
------------

// File: rtl/interval_tick_servicer_pkg.sv
// Shared constants for the interval tick servicer: CPU register map, CTRL bit
// positions and the timer-clear sequencer states.
package interval_tick_servicer_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_TICK_L = 3'd1;
  localparam logic [2:0] ADDR_TICK_H = 3'd2;
  localparam logic [2:0] ADDR_DIVIDE = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int CTRL_SVC_EN = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLR    = 2'd1,
    ST_SETTLE = 2'd2
  } svc_state_e;

endpackage

// File: rtl/interval_tick_servicer_if.sv
// Bus bundles for the servicer: the CPU-facing Avalon-MM slave and the
// master port that clears the interval timer's TO flag.
interface interval_tick_servicer_cpu_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport slave  (input address, chipselect, read_n, write_n, writedata,
                  output readdata, irq);
  modport master (output address, chipselect, read_n, write_n, writedata,
                  input readdata, irq);
endinterface

interface interval_tick_servicer_tmr_if;
  logic        tmr_irq;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;

  modport master (input tmr_irq,
                  output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata);
  modport slave  (output tmr_irq,
                  input tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata);
endinterface

// File: rtl/interval_tick_servicer.sv
// Clears the interval timer's TO flag on each timer irq, counts serviced
// ticks and raises a divided interrupt every DIVIDE+1 ticks.
//
// state  | meaning
// IDLE   | master idle, waiting for svc_en & tmr_irq
// CLR    | one-cycle write of 0 to the timer status register; tick counted
// SETTLE | master idle one cycle while the timer's registered irq drops
module interval_tick_servicer
  import interval_tick_servicer_pkg::*;
#(
  parameter logic [2:0] TMR_STATUS_ADDR = 3'd0,
  parameter int         DIV_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  interval_tick_servicer_cpu_if.slave   cpu,
  interval_tick_servicer_tmr_if.master  tmr
);

  svc_state_e           r_state;
  logic                 r_tmr_cs;
  logic                 r_tmr_wn;
  logic [1:0]           r_ctrl;
  logic [31:0]          r_tick_cnt;
  logic [15:0]          r_tick_h_snap;
  logic [DIV_WIDTH-1:0] r_divide;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_pending;
  logic [15:0]          r_readdata;

  logic                 w_wr;
  logic                 w_rd;
  logic                 w_tick;
  logic                 w_busy;
  logic                 w_tick_clr;
  logic                 w_div_wr;
  logic                 w_status_wr;
  logic                 w_event;
  logic [15:0]          w_rd_mux;

  assign w_wr        = cpu.chipselect & ~cpu.write_n;
  assign w_rd        = cpu.chipselect & ~cpu.read_n;
  assign w_tick      = (r_state == ST_CLR);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_tick_clr  = w_wr & ((cpu.address == ADDR_TICK_L) | (cpu.address == ADDR_TICK_H));
  assign w_div_wr    = w_wr & (cpu.address == ADDR_DIVIDE);
  assign w_status_wr = w_wr & (cpu.address == ADDR_STATUS);
  // A DIVIDE write restarts the division, so a coincident tick produces no event.
  assign w_event     = w_tick & ~w_div_wr & (r_div_cnt == r_divide);

  assign cpu.readdata       = r_readdata;
  assign cpu.irq            = r_pending & r_ctrl[CTRL_IRQ_EN];
  assign tmr.tmr_address    = TMR_STATUS_ADDR;
  assign tmr.tmr_chipselect = r_tmr_cs;
  assign tmr.tmr_write_n    = r_tmr_wn;
  assign tmr.tmr_writedata  = 16'h0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_tmr_cs <= 1'b0;
      r_tmr_wn <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_ctrl[CTRL_SVC_EN] && tmr.tmr_irq) begin
            r_state  <= ST_CLR;
            r_tmr_cs <= 1'b1;
            r_tmr_wn <= 1'b0;
          end
        end
        ST_CLR: begin
          r_state  <= ST_SETTLE;
          r_tmr_cs <= 1'b0;
          r_tmr_wn <= 1'b1;
        end
        ST_SETTLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tmr_cs <= 1'b0;
          r_tmr_wn <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = 16'h0000;
    case (cpu.address)
      ADDR_CTRL:   w_rd_mux = {14'h0000, r_ctrl};
      ADDR_TICK_L: w_rd_mux = r_tick_cnt[15:0];
      ADDR_TICK_H: w_rd_mux = r_tick_h_snap;
      ADDR_DIVIDE: w_rd_mux = 16'(r_divide);
      ADDR_STATUS: w_rd_mux = {14'h0000, w_busy, r_pending};
      default:     w_rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl        <= 2'b00;
      r_tick_cnt    <= 32'h0000_0000;
      r_tick_h_snap <= 16'h0000;
      r_divide      <= '0;
      r_div_cnt     <= '0;
      r_pending     <= 1'b0;
      r_readdata    <= 16'h0000;
    end else begin
      r_readdata <= w_rd_mux;

      if (w_wr && (cpu.address == ADDR_CTRL)) r_ctrl <= cpu.writedata[1:0];
      if (w_div_wr) r_divide <= cpu.writedata[DIV_WIDTH-1:0];

      // High half is frozen on the TICK_L read so a 32-bit read pair is coherent.
      if (w_rd && (cpu.address == ADDR_TICK_L)) r_tick_h_snap <= r_tick_cnt[31:16];

      if (w_tick_clr)  r_tick_cnt <= 32'h0000_0000;
      else if (w_tick) r_tick_cnt <= r_tick_cnt + 32'd1;

      if (w_div_wr)     r_div_cnt <= '0;
      else if (w_event) r_div_cnt <= '0;
      else if (w_tick)  r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);

      if (w_event)          r_pending <= 1'b1;
      else if (w_status_wr) r_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interval_tick_servicer.sv
// Directed bench for interval_tick_servicer with hand-computed expectations.
module tb_interval_tick_servicer;
  import interval_tick_servicer_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   wc;
  logic [15:0] rd;
  bit   seen;

  interval_tick_servicer_cpu_if cpu_if ();
  interval_tick_servicer_tmr_if tmr_if ();

  interval_tick_servicer #(
    .TMR_STATUS_ADDR (3'd0),
    .DIV_WIDTH       (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu     (cpu_if),
    .tmr     (tmr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_if.address    = a;
    cpu_if.writedata  = d;
    cpu_if.chipselect = 1'b1;
    cpu_if.write_n    = 1'b0;
    @(negedge clk);
    cpu_if.chipselect = 1'b0;
    cpu_if.write_n    = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    cpu_if.address    = a;
    cpu_if.chipselect = 1'b1;
    cpu_if.read_n     = 1'b0;
    @(negedge clk);
    d = cpu_if.readdata;
    cpu_if.chipselect = 1'b0;
    cpu_if.read_n     = 1'b1;
  endtask

  // Raises tmr_irq and watches the master for `cycles` clocks. With drop set the
  // timer model lowers irq on the clearing write; with sw set a CPU write is
  // issued so that it lands on the same edge as the counted tick.
  task automatic timer_tick(input bit drop, input bit sw, input logic [2:0] sw_a,
                            input logic [15:0] sw_d, input int cycles, output int n);
    n = 0;
    @(negedge clk);
    tmr_if.tmr_irq = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      cpu_if.chipselect = 1'b0;
      cpu_if.write_n    = 1'b1;
      if (tmr_if.tmr_chipselect && !tmr_if.tmr_write_n) begin
        n++;
        check("tmr_address", 32'(tmr_if.tmr_address), 32'h0);
        check("tmr_writedata", 32'(tmr_if.tmr_writedata), 32'h0);
        if (drop) tmr_if.tmr_irq = 1'b0;
        if (sw && n == 1) begin
          cpu_if.address    = sw_a;
          cpu_if.writedata  = sw_d;
          cpu_if.chipselect = 1'b1;
          cpu_if.write_n    = 1'b0;
        end
      end
    end
    tmr_if.tmr_irq = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    cpu_if.address    = 3'd0;
    cpu_if.chipselect = 1'b0;
    cpu_if.read_n     = 1'b1;
    cpu_if.write_n    = 1'b1;
    cpu_if.writedata  = 16'h0;
    tmr_if.tmr_irq    = 1'b0;
    #1 reset_n = 1'b0;
    #12;
    check("rst_irq", 32'(cpu_if.irq), 32'h0);
    check("rst_tmr_cs", 32'(tmr_if.tmr_chipselect), 32'h0);
    check("rst_tmr_wn", 32'(tmr_if.tmr_write_n), 32'h1);
    check("rst_readdata", 32'(cpu_if.readdata), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      cpu_read(3'(a), rd);
      check($sformatf("rst_read_%0d", a), 32'(rd), 32'h0);
    end

    // Single serviced tick with svc_en only.
    cpu_write(ADDR_CTRL, 16'h0001);
    timer_tick(1'b1, 1'b0, 3'd0, 16'h0, 6, wc);
    check("t2_writes", 32'(wc), 32'd1);
    cpu_read(ADDR_TICK_L, rd);
    check("t2_tick_l", 32'(rd), 32'd1);
    cpu_read(ADDR_TICK_H, rd);
    check("t2_tick_h", 32'(rd), 32'd0);
    check("t2_irq_masked", 32'(cpu_if.irq), 32'h0);
    cpu_read(ADDR_STATUS, rd);
    check("t2_status", 32'(rd), 32'h1);

    // Divide by three: events after ticks 3 and 6.
    cpu_write(ADDR_STATUS, 16'h0);
    cpu_write(ADDR_DIVIDE, 16'd2);
    cpu_write(ADDR_CTRL, 16'h0003);
    cpu_read(ADDR_CTRL, rd);
    check("t3_ctrl_rb", 32'(rd), 32'h3);
    for (int k = 1; k <= 6; k++) begin
      timer_tick(1'b1, 1'b0, 3'd0, 16'h0, 6, wc);
      check($sformatf("t3_writes_%0d", k), 32'(wc), 32'd1);
      check($sformatf("t3_irq_%0d", k), 32'(cpu_if.irq), (k % 3 == 0) ? 32'h1 : 32'h0);
      if (k % 3 == 0) begin
        cpu_write(ADDR_STATUS, 16'h0);
        check($sformatf("t3_irq_clr_%0d", k), 32'(cpu_if.irq), 32'h0);
      end
    end
    cpu_read(ADDR_TICK_L, rd);
    check("t3_tick_l", 32'(rd), 32'd7);
    cpu_read(ADDR_DIVIDE, rd);
    check("t3_divide_rb", 32'(rd), 32'd2);

    // Carry into the high half and full 32-bit wrap, via backdoor preload.
    dut.r_tick_cnt = 32'h0001_FFFF;
    timer_tick(1'b1, 1'b0, 3'd0, 16'h0, 6, wc);
    cpu_read(ADDR_TICK_L, rd);
    check("t4_carry_l", 32'(rd), 32'h0);
    cpu_read(ADDR_TICK_H, rd);
    check("t4_carry_h", 32'(rd), 32'h2);
    dut.r_tick_cnt = 32'hFFFF_FFFF;
    timer_tick(1'b1, 1'b0, 3'd0, 16'h0, 6, wc);
    cpu_read(ADDR_TICK_L, rd);
    check("t4_wrap_l", 32'(rd), 32'h0);
    cpu_read(ADDR_TICK_H, rd);
    check("t4_wrap_h", 32'(rd), 32'h0);

    // STATUS clear coincident with event: set wins.
    cpu_write(ADDR_DIVIDE, 16'd0);
    cpu_write(ADDR_STATUS, 16'h0);
    check("t5_irq_pre", 32'(cpu_if.irq), 32'h0);
    timer_tick(1'b1, 1'b1, ADDR_STATUS, 16'h0, 6, wc);
    check("t5_irq", 32'(cpu_if.irq), 32'h1);
    cpu_read(ADDR_STATUS, rd);
    check("t5_status", 32'(rd), 32'h1);

    // TICK_L write coincident with tick: clear wins.
    timer_tick(1'b1, 1'b1, ADDR_TICK_L, 16'h0, 6, wc);
    cpu_read(ADDR_TICK_L, rd);
    check("t5_tickclr", 32'(rd), 32'h0);

    // DIVIDE write coincident with tick: no event, division restarts.
    cpu_write(ADDR_STATUS, 16'h0);
    timer_tick(1'b1, 1'b1, ADDR_DIVIDE, 16'd1, 6, wc);
    check("t5_divwr_irq1", 32'(cpu_if.irq), 32'h0);
    timer_tick(1'b1, 1'b0, 3'd0, 16'h0, 6, wc);
    check("t5_divwr_irq2", 32'(cpu_if.irq), 32'h0);
    timer_tick(1'b1, 1'b0, 3'd0, 16'h0, 6, wc);
    check("t5_divwr_irq3", 32'(cpu_if.irq), 32'h1);

    // tmr_irq held high: a new clear every three clocks.
    cpu_write(ADDR_CTRL, 16'h0001);
    timer_tick(1'b0, 1'b0, 3'd0, 16'h0, 8, wc);
    check("held_writes", 32'(wc), 32'd3);
    repeat (3) @(negedge clk);

    // svc_en dropped during CLR: sequence completes, nothing restarts.
    timer_tick(1'b0, 1'b1, ADDR_CTRL, 16'h0000, 8, wc);
    check("t6_writes", 32'(wc), 32'd1);
    cpu_read(ADDR_STATUS, rd);
    check("t6_busy", 32'(rd & 16'h0002), 32'h0);

    // Reset in the middle of a clear returns the master to idle at once.
    cpu_write(ADDR_CTRL, 16'h0001);
    tmr_if.tmr_irq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (tmr_if.tmr_chipselect) seen = 1'b1;
    end
    check("t7_clr_seen", 32'(seen), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_async_cs", 32'(tmr_if.tmr_chipselect), 32'h0);
    check("t7_async_wn", 32'(tmr_if.tmr_write_n), 32'h1);
    tmr_if.tmr_irq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_read(ADDR_CTRL, rd);
    check("t7_ctrl_rst", 32'(rd), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
